// File: rtl/dino_sprite_renderer.sv
// Dino sprite renderer: consumes VGA X/Y counters, runs once-per-frame jump
// physics during vertical blanking, and paints a 16x16 sprite plus a ground
// stripe with a single registered pixel stage.
module dino_sprite_renderer #(
  parameter int unsigned  DINO_X   = 80,
  parameter int unsigned  GROUND_Y = 400,
  parameter int unsigned  JUMP_V   = 12,
  parameter int unsigned  GRAVITY  = 1,
  parameter logic [11:0]  FG_RGB   = 12'hFFF,
  parameter logic [11:0]  GND_RGB  = 12'h888
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic [9:0] counter_x,
  input  logic [9:0] counter_y,
  input  logic       in_display,
  input  logic       jump_btn,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b,
  output logic [8:0] dino_y,
  output logic       airborne
);

  localparam logic [9:0] DINO_X_C   = 10'(DINO_X);
  localparam logic [8:0] GROUND_Y_C = 9'(GROUND_Y);
  localparam logic [9:0] GND_LINE_C = 10'(GROUND_Y + 16);
  localparam logic [4:0] JUMP_V_C   = 5'(JUMP_V);
  localparam logic [4:0] GRAVITY_C  = 5'(GRAVITY);

  typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

  // Sprite bitmap, bit 15 is the leftmost pixel of each row.
  function automatic logic [15:0] sprite_row(input logic [3:0] row);
    logic [15:0] bits;
    case (row)
      4'd0:    bits = 16'h07F0;
      4'd1:    bits = 16'h0FF8;
      4'd2:    bits = 16'h0DF8;
      4'd3:    bits = 16'h0FF8;
      4'd4:    bits = 16'h0FC0;
      4'd5:    bits = 16'h0FF0;
      4'd6:    bits = 16'h8F80;
      4'd7:    bits = 16'h9FC0;
      4'd8:    bits = 16'hFFF8;
      4'd9:    bits = 16'hFFE0;
      4'd10:   bits = 16'h7FC0;
      4'd11:   bits = 16'h3F80;
      4'd12:   bits = 16'h1F00;
      4'd13:   bits = 16'h0E00;
      4'd14:   bits = 16'h0C60;
      default: bits = 16'h6C36;
    endcase
    return bits;
  endfunction

  // Button synchronizer: [0],[1] are the two sync flops, [2] the edge history.
  logic [2:0]  sync_q, sync_d;
  logic        jump_req_q, jump_req_d;
  logic        btn_rise;
  logic        frame_tick;

  state_t      state_q, state_d;
  logic [4:0]  vel_q, vel_d;
  logic [8:0]  dino_y_q, dino_y_d;
  logic        airborne_q, airborne_d;
  logic [9:0]  y_next;

  logic [11:0] rgb_q, rgb_d;
  logic [9:0]  dx, dy;
  logic [15:0] rom_bits;
  logic        sprite_hit, ground_hit;

  assign frame_tick = pix_en && (counter_x == 10'd0) && (counter_y == 10'd480);
  assign btn_rise   = sync_q[1] & ~sync_q[2];

  // Sticky jump request: a tick always clears it, but an edge landing on the
  // tick cycle survives into the next frame.
  always_comb begin
    sync_d     = {sync_q[1:0], jump_btn};
    jump_req_d = frame_tick ? btn_rise : (jump_req_q | btn_rise);
  end

  // Synchronizer and request flag run at full clock rate, not gated by pix_en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= 3'b000;
      jump_req_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      jump_req_q <= jump_req_d;
    end
  end

  // Jump physics next-state; only moves on the first blanking line.
  always_comb begin
    state_d  = state_q;
    vel_d    = vel_q;
    dino_y_d = dino_y_q;
    y_next   = {1'b0, dino_y_q} + {5'd0, vel_q};
    if (frame_tick) begin
      case (state_q)
        GROUND: begin
          if (jump_req_q) begin
            state_d = RISE;
            vel_d   = JUMP_V_C;
          end
        end
        RISE: begin
          dino_y_d = dino_y_q - {4'd0, vel_q};
          if (vel_q <= GRAVITY_C) begin
            state_d = FALL;
            vel_d   = 5'd0;
          end else begin
            vel_d   = vel_q - GRAVITY_C;
          end
        end
        default: begin
          // Clamp at ground so any parameter set lands exactly on GROUND_Y.
          if (y_next >= {1'b0, GROUND_Y_C}) begin
            state_d  = GROUND;
            vel_d    = 5'd0;
            dino_y_d = GROUND_Y_C;
          end else begin
            vel_d    = vel_q + GRAVITY_C;
            dino_y_d = y_next[8:0];
          end
        end
      endcase
    end
    airborne_d = (state_d != GROUND);
  end

  // Physics state registers with registered airborne flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= GROUND;
      vel_q      <= 5'd0;
      dino_y_q   <= GROUND_Y_C;
      airborne_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      vel_q      <= vel_d;
      dino_y_q   <= dino_y_d;
      airborne_q <= airborne_d;
    end
  end

  // Pixel colour: offsets wrap unsigned, so "offset < 16" is the window test.
  always_comb begin
    dx         = counter_x - DINO_X_C;
    dy         = counter_y - {1'b0, dino_y_q};
    rom_bits   = sprite_row(dy[3:0]);
    sprite_hit = in_display && (dx < 10'd16) && (dy < 10'd16) &&
                 rom_bits[4'd15 - dx[3:0]];
    ground_hit = in_display && (counter_y == GND_LINE_C);
    rgb_d      = rgb_q;
    if (pix_en) begin
      rgb_d = sprite_hit ? FG_RGB : (ground_hit ? GND_RGB : 12'h000);
    end
  end

  // Single registered pixel stage, holds while pix_en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q <= 12'h000;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign r        = rgb_q[11:8];
  assign g        = rgb_q[7:4];
  assign b        = rgb_q[3:0];
  assign dino_y   = dino_y_q;
  assign airborne = airborne_q;

endmodule

// File: tb/tb_dino_sprite_renderer.sv
// Directed bench for dino_sprite_renderer: drives the counters directly so a
// "frame" is a single cycle at (0,480) rather than a full raster.
module tb_dino_sprite_renderer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pix_en = 1'b0;
  logic [9:0] counter_x = 10'd700;
  logic [9:0] counter_y = 10'd100;
  logic       in_display = 1'b0;
  logic       jump_btn = 1'b0;
  logic [3:0] r, g, b;
  logic [8:0] dino_y;
  logic       airborne;

  int errors = 0;
  int checks = 0;

  // Hand-computed trajectory after launch: 12 RISE ticks, 13 FALL ticks.
  int exp_y [25] = '{388, 377, 367, 358, 350, 343, 337, 332, 328, 325, 323, 322,
                     322, 323, 325, 328, 332, 337, 343, 350, 358, 367, 377, 388, 400};

  dino_sprite_renderer dut (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .counter_x  (counter_x),
    .counter_y  (counter_y),
    .in_display (in_display),
    .jump_btn   (jump_btn),
    .r          (r),
    .g          (g),
    .b          (b),
    .dino_y     (dino_y),
    .airborne   (airborne)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic set_in(input logic en, input logic [9:0] x, input logic [9:0] y, input logic d);
    pix_en     = en;
    counter_x  = x;
    counter_y  = y;
    in_display = d;
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    set_in(1'b1, 10'd0, 10'd480, 1'b0);
    cycle();
    set_in(1'b1, 10'd700, 10'd100, 1'b0);
    cycle();
  endtask

  task automatic pixel(input logic [9:0] x, input logic [9:0] y, input logic d,
                       input logic [11:0] exp, input string tag);
    set_in(1'b1, x, y, d);
    cycle();
    chk(tag, {20'd0, r, g, b}, {20'd0, exp});
    set_in(1'b1, 10'd700, 10'd100, 1'b0);
  endtask

  task automatic press();
    jump_btn = 1'b1;
    repeat (4) cycle();
    jump_btn = 1'b0;
    repeat (5) cycle();
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_dino_y", 32'(dino_y), 32'd400);
    chk("rst_airborne", 32'(airborne), 32'd0);
    chk("rst_rgb", {20'd0, r, g, b}, 32'h000);
    cycle();
    rst = 1'b1;
    set_in(1'b1, 10'd700, 10'd100, 1'b0);
    cycle();

    // Idle frames: stays on ground
    repeat (3) frame();
    chk("idle_dino_y", 32'(dino_y), 32'd400);
    chk("idle_airborne", 32'(airborne), 32'd0);

    // Pixel rendering while standing at y=400
    pixel(10'd80,  10'd400, 1'b1, 12'h000, "px_80_400");
    pixel(10'd85,  10'd400, 1'b1, 12'hFFF, "px_85_400");
    pixel(10'd100, 10'd416, 1'b1, 12'h888, "px_ground");
    pixel(10'd700, 10'd100, 1'b1, 12'h000, "px_bg");
    pixel(10'd81,  10'd415, 1'b1, 12'hFFF, "px_row15_c1");
    pixel(10'd80,  10'd415, 1'b1, 12'h000, "px_row15_c0");
    pixel(10'd88,  10'd408, 1'b1, 12'hFFF, "px_row8_c8");
    pixel(10'd96,  10'd408, 1'b1, 12'h000, "px_right_edge");
    pixel(10'd85,  10'd399, 1'b1, 12'h000, "px_above_top");
    pixel(10'd85,  10'd416, 1'b1, 12'h888, "px_below_bottom");
    pixel(10'd85,  10'd400, 1'b0, 12'h000, "px_no_display");

    // Output holds while pix_en is low
    pixel(10'd85, 10'd400, 1'b1, 12'hFFF, "px_before_hold");
    set_in(1'b0, 10'd700, 10'd100, 1'b0);
    repeat (5) cycle();
    chk("px_hold", {20'd0, r, g, b}, 32'hFFF);
    set_in(1'b1, 10'd700, 10'd100, 1'b0);
    cycle();

    // Jump: tick position without pix_en must not fire
    press();
    set_in(1'b0, 10'd0, 10'd480, 1'b0);
    cycle();
    chk("no_tick_wo_pix_en", 32'(airborne), 32'd0);
    set_in(1'b1, 10'd700, 10'd100, 1'b0);
    frame();
    chk("launch_airborne", 32'(airborne), 32'd1);
    chk("launch_dino_y", 32'(dino_y), 32'd400);
    for (int i = 0; i < 25; i++) begin
      frame();
      chk($sformatf("jump1_y_t%0d", i + 1), 32'(dino_y), 32'(exp_y[i]));
      chk($sformatf("jump1_air_t%0d", i + 1), 32'(airborne), (i < 24) ? 32'd1 : 32'd0);
      if (i == 0) pixel(10'd85, 10'd388, 1'b1, 12'hFFF, "px_airborne_top");
      if (i == 11) press();  // press at apex is discarded
    end
    repeat (2) frame();
    chk("apex_press_ignored", 32'(airborne), 32'd0);

    // Held button gives exactly one jump
    jump_btn = 1'b1;
    repeat (5) cycle();
    frame();
    chk("hold_launch", 32'(airborne), 32'd1);
    repeat (25) frame();
    chk("hold_land_y", 32'(dino_y), 32'd400);
    chk("hold_land_air", 32'(airborne), 32'd0);
    for (int i = 0; i < 3; i++) begin
      frame();
      chk($sformatf("hold_no_rejump_%0d", i), 32'(airborne), 32'd0);
    end
    jump_btn = 1'b0;
    repeat (5) cycle();

    // Asynchronous reset during FALL at y=350
    press();
    frame();
    repeat (20) frame();
    chk("pre_rst_y", 32'(dino_y), 32'd350);
    pixel(10'd100, 10'd416, 1'b1, 12'h888, "pre_rst_rgb");
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_y", 32'(dino_y), 32'd400);
    chk("async_rst_air", 32'(airborne), 32'd0);
    chk("async_rst_rgb", {20'd0, r, g, b}, 32'h000);
    cycle();
    rst = 1'b1;
    cycle();
    repeat (3) frame();
    chk("post_rst_air", 32'(airborne), 32'd0);
    chk("post_rst_y", 32'(dino_y), 32'd400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
